// File: rtl/cam_lru.sv
// Fully-associative CAM with true-LRU replacement. One command per cycle; all
// results are registered and visible the cycle after the command edge.

module cam_lru_entry #(
  parameter int DATA_W = 32
) (
  input  logic              valid_i,
  input  logic [DATA_W-1:0] entry_i,
  input  logic [DATA_W-1:0] key_i,
  output logic              match_o
);
  assign match_o = valid_i && (entry_i == key_i);
endmodule

module cam_lru #(
  parameter int DATA_W = 32,
  parameter int SIZE   = 8,
  parameter int IDX_W  = $clog2(SIZE)
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic [1:0]        cmd_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [IDX_W-1:0]  write_idx_i,
  input  logic              flush_i,
  output logic              resp_valid_o,
  output logic              hit_o,
  output logic [IDX_W-1:0]  hit_idx_o,
  output logic              multi_hit_o,
  output logic [IDX_W-1:0]  alloc_idx_o,
  output logic              evict_o,
  output logic [DATA_W-1:0] evict_data_o,
  output logic              full_o,
  output logic [IDX_W:0]    valid_count_o
);

  localparam logic [1:0] CMD_LOOKUP = 2'b01;
  localparam logic [1:0] CMD_WRITE  = 2'b10;
  localparam logic [1:0] CMD_ALLOC  = 2'b11;

  typedef struct packed {
    logic              hit;
    logic [IDX_W-1:0]  hit_idx;
    logic              multi_hit;
    logic [IDX_W-1:0]  alloc_idx;
    logic              evict;
    logic [DATA_W-1:0] evict_data;
  } resp_t;

  logic [SIZE-1:0][DATA_W-1:0] entry_q;
  logic [SIZE-1:0]             valid_q, valid_d;
  logic [SIZE-1:0][IDX_W-1:0]  age_q, age_d;
  logic [SIZE-1:0]             match;
  logic [IDX_W:0]              cnt_q, cnt_d;
  logic                        full_q, full_d;
  logic                        resp_valid_q, resp_valid_d;
  resp_t                       resp_q, resp_d;

  genvar g;
  generate
    for (g = 0; g < SIZE; g++) begin : g_ent
      cam_lru_entry #(.DATA_W(DATA_W)) u_ent (
        .valid_i (valid_q[g]),
        .entry_i (entry_q[g]),
        .key_i   (data_i),
        .match_o (match[g])
      );
    end
  endgenerate

  logic             hit_any, multi, free_any;
  logic [IDX_W-1:0] hit_idx, free_idx, lru_idx;

  always_comb begin
    hit_any  = |match;
    multi    = (match & (match - SIZE'(1))) != '0;
    free_any = ~&valid_q;
    hit_idx  = '0;
    free_idx = '0;
    lru_idx  = '0;
    // Descending scans so the lowest qualifying index wins.
    for (int i = SIZE-1; i >= 0; i--) begin
      if (match[i])   hit_idx  = IDX_W'(i);
      if (!valid_q[i]) free_idx = IDX_W'(i);
      if (age_q[i] == IDX_W'(SIZE-1)) lru_idx = IDX_W'(i);
    end
  end

  logic             accept, do_write, do_touch;
  logic [IDX_W-1:0] wr_idx, touch_idx;

  always_comb begin
    accept    = enable_i && (cmd_i != 2'b00) && !flush_i;
    do_write  = 1'b0;
    do_touch  = 1'b0;
    wr_idx    = '0;
    touch_idx = '0;
    if (accept) begin
      unique case (cmd_i)
        CMD_LOOKUP: begin
          do_touch  = hit_any;
          touch_idx = hit_idx;
        end
        CMD_WRITE: begin
          do_write  = 1'b1;
          wr_idx    = write_idx_i;
          do_touch  = 1'b1;
          touch_idx = write_idx_i;
        end
        CMD_ALLOC: begin
          if (hit_any) begin
            do_touch  = 1'b1;
            touch_idx = hit_idx;
          end else begin
            do_write  = 1'b1;
            wr_idx    = free_any ? free_idx : lru_idx;
            do_touch  = 1'b1;
            touch_idx = wr_idx;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    valid_d = valid_q;
    age_d   = age_q;
    if (do_write) valid_d[wr_idx] = 1'b1;
    // Everything younger than the touched entry ages by one; it becomes MRU.
    if (do_touch) begin
      for (int j = 0; j < SIZE; j++)
        if (age_q[j] < age_q[touch_idx]) age_d[j] = age_q[j] + IDX_W'(1);
      age_d[touch_idx] = '0;
    end
    if (flush_i) begin
      valid_d = '0;
      for (int j = 0; j < SIZE; j++) age_d[j] = IDX_W'(j);
    end
    cnt_d = '0;
    for (int j = 0; j < SIZE; j++) cnt_d = cnt_d + (IDX_W+1)'(valid_d[j]);
    full_d = (cnt_d == (IDX_W+1)'(SIZE));
  end

  always_comb begin
    resp_valid_d = accept;
    resp_d       = resp_q;
    if (accept) begin
      unique case (cmd_i)
        CMD_LOOKUP: begin
          resp_d.hit       = hit_any;
          resp_d.hit_idx   = hit_idx;
          resp_d.multi_hit = multi;
          resp_d.evict     = 1'b0;
        end
        CMD_WRITE: begin
          resp_d.hit       = 1'b0;
          resp_d.hit_idx   = '0;
          resp_d.multi_hit = 1'b0;
          resp_d.evict     = 1'b0;
        end
        CMD_ALLOC: begin
          resp_d.hit       = hit_any;
          resp_d.hit_idx   = hit_idx;
          resp_d.multi_hit = multi;
          resp_d.alloc_idx = hit_any ? hit_idx : wr_idx;
          resp_d.evict     = !hit_any && !free_any;
          if (!hit_any && !free_any) resp_d.evict_data = entry_q[lru_idx];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      valid_q      <= '0;
      cnt_q        <= '0;
      full_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_q       <= '0;
      for (int j = 0; j < SIZE; j++) age_q[j] <= IDX_W'(j);
    end else begin
      valid_q      <= valid_d;
      age_q        <= age_d;
      cnt_q        <= cnt_d;
      full_q       <= full_d;
      resp_valid_q <= resp_valid_d;
      resp_q       <= resp_d;
    end
  end

  // Payload storage is never reset; the valid bits gate every use of it.
  always_ff @(posedge clock_i) begin
    if (do_write) entry_q[wr_idx] <= data_i;
  end

  assign resp_valid_o  = resp_valid_q;
  assign hit_o         = resp_q.hit;
  assign hit_idx_o     = resp_q.hit_idx;
  assign multi_hit_o   = resp_q.multi_hit;
  assign alloc_idx_o   = resp_q.alloc_idx;
  assign evict_o       = resp_q.evict;
  assign evict_data_o  = resp_q.evict_data;
  assign full_o        = full_q;
  assign valid_count_o = cnt_q;

endmodule

// File: tb/tb_cam_lru.sv
// Directed self-checking bench for cam_lru (DATA_W=32, SIZE=8).

module tb_cam_lru;

  localparam int DATA_W = 32;
  localparam int SIZE   = 8;
  localparam int IDX_W  = 3;

  localparam logic [1:0] NOP = 2'b00, LOOKUP = 2'b01, WRITE = 2'b10, ALLOC = 2'b11;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              enable = 1'b0;
  logic [1:0]        cmd = 2'b00;
  logic [DATA_W-1:0] data = '0;
  logic [IDX_W-1:0]  widx = '0;
  logic              flush = 1'b0;
  logic              resp_valid, hit, multi_hit, evict, full;
  logic [IDX_W-1:0]  hit_idx, alloc_idx;
  logic [DATA_W-1:0] evict_data;
  logic [IDX_W:0]    valid_count;

  int checks = 0;
  int failures = 0;

  cam_lru #(.DATA_W(DATA_W), .SIZE(SIZE)) dut (
    .clock_i       (clock),
    .reset_i       (reset),
    .enable_i      (enable),
    .cmd_i         (cmd),
    .data_i        (data),
    .write_idx_i   (widx),
    .flush_i       (flush),
    .resp_valid_o  (resp_valid),
    .hit_o         (hit),
    .hit_idx_o     (hit_idx),
    .multi_hit_o   (multi_hit),
    .alloc_idx_o   (alloc_idx),
    .evict_o       (evict),
    .evict_data_o  (evict_data),
    .full_o        (full),
    .valid_count_o (valid_count)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  // Drive a command at a negedge; returns at the next negedge, when its response is readable.
  task automatic issue(input logic [1:0] c, input logic [DATA_W-1:0] d, input logic [IDX_W-1:0] i);
    enable = 1'b1; cmd = c; data = d; widx = i;
    @(negedge clock);
    enable = 1'b0; cmd = NOP;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic fill8();
    for (int i = 0; i < SIZE; i++) issue(ALLOC, 32'h10 + i, '0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid got=%0h exp=0", resp_valid); end
    checks++; if (valid_count !== 4'd0) begin failures++; $display("FAIL rst_valid_count got=%0h exp=0", valid_count); end
    checks++; if ({hit, multi_hit, evict, full, hit_idx, alloc_idx, evict_data} !== '0) begin
      failures++; $display("FAIL rst_outputs got=%0h exp=0", {hit, multi_hit, evict, full, hit_idx, alloc_idx, evict_data}); end
    @(negedge clock);
    reset = 1'b1;
    issue(LOOKUP, 32'h0, '0);
    checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL rst_lookup_rv got=%0h exp=1", resp_valid); end
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL rst_lookup_hit got=%0h exp=0", hit); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL rst_lookup_full got=%0h exp=0", full); end
  endtask

  task automatic test_write_lookup();
    do_reset();
    issue(WRITE, 32'hDEADBEEF, 3'd3);
    checks++; if (resp_valid !== 1'b1 || hit !== 1'b0) begin failures++; $display("FAIL wr_resp got=%0h%0h exp=10", resp_valid, hit); end
    checks++; if (valid_count !== 4'd1) begin failures++; $display("FAIL wr_count got=%0h exp=1", valid_count); end
    issue(LOOKUP, 32'hDEADBEEF, '0);
    checks++; if (hit !== 1'b1) begin failures++; $display("FAIL lk_hit got=%0h exp=1", hit); end
    checks++; if (hit_idx !== 3'd3) begin failures++; $display("FAIL lk_hit_idx got=%0h exp=3", hit_idx); end
    checks++; if (multi_hit !== 1'b0) begin failures++; $display("FAIL lk_multi got=%0h exp=0", multi_hit); end
    @(negedge clock);
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL idle_rv got=%0h exp=0", resp_valid); end
    checks++; if (hit !== 1'b1 || hit_idx !== 3'd3) begin failures++; $display("FAIL idle_hold got=%0h/%0h exp=1/3", hit, hit_idx); end
  endtask

  task automatic test_alloc_fill();
    do_reset();
    for (int i = 0; i < SIZE; i++) begin
      issue(ALLOC, 32'h10 + i, '0);
      checks++; if (alloc_idx !== IDX_W'(i) || evict !== 1'b0 || hit !== 1'b0) begin
        failures++; $display("FAIL fill_%0d got=idx%0h ev%0h hit%0h exp=idx%0h ev0 hit0", i, alloc_idx, evict, hit, i); end
      checks++; if (valid_count !== 4'(i+1) || full !== (i == SIZE-1)) begin
        failures++; $display("FAIL fill_cnt_%0d got=%0h/%0h exp=%0h/%0h", i, valid_count, full, i+1, i == SIZE-1); end
    end
    issue(ALLOC, 32'h99, '0);
    checks++; if (alloc_idx !== 3'd0 || evict !== 1'b1) begin failures++; $display("FAIL evict0 got=idx%0h ev%0h exp=idx0 ev1", alloc_idx, evict); end
    checks++; if (evict_data !== 32'h10) begin failures++; $display("FAIL evict0_data got=%0h exp=10", evict_data); end
    checks++; if (valid_count !== 4'd8 || full !== 1'b1) begin failures++; $display("FAIL evict0_full got=%0h/%0h exp=8/1", valid_count, full); end
  endtask

  task automatic test_lru_touch();
    do_reset();
    fill8();
    issue(LOOKUP, 32'h10, '0);
    checks++; if (hit !== 1'b1 || hit_idx !== 3'd0) begin failures++; $display("FAIL touch0 got=%0h/%0h exp=1/0", hit, hit_idx); end
    issue(ALLOC, 32'h99, '0);
    checks++; if (alloc_idx !== 3'd1 || evict !== 1'b1 || evict_data !== 32'h11) begin
      failures++; $display("FAIL evict1 got=idx%0h ev%0h d%0h exp=idx1 ev1 d11", alloc_idx, evict, evict_data); end
    issue(ALLOC, 32'h12, '0);
    checks++; if (hit !== 1'b1 || alloc_idx !== 3'd2 || evict !== 1'b0) begin
      failures++; $display("FAIL alloc_hit got=hit%0h idx%0h ev%0h exp=hit1 idx2 ev0", hit, alloc_idx, evict); end
    issue(LOOKUP, 32'h55, '0);
    checks++; if (hit !== 1'b0 || hit_idx !== 3'd0) begin failures++; $display("FAIL miss got=%0h/%0h exp=0/0", hit, hit_idx); end
    // Entry 3 is now oldest; the miss above must not have disturbed the order.
    issue(ALLOC, 32'h77, '0);
    checks++; if (alloc_idx !== 3'd3 || evict_data !== 32'h13) begin
      failures++; $display("FAIL evict3 got=idx%0h d%0h exp=idx3 d13", alloc_idx, evict_data); end
  endtask

  task automatic test_multi_hit();
    do_reset();
    issue(WRITE, 32'hAA, 3'd5);
    issue(WRITE, 32'hAA, 3'd2);
    issue(LOOKUP, 32'hAA, '0);
    checks++; if (hit !== 1'b1 || hit_idx !== 3'd2) begin failures++; $display("FAIL dup_idx got=%0h/%0h exp=1/2", hit, hit_idx); end
    checks++; if (multi_hit !== 1'b1) begin failures++; $display("FAIL dup_multi got=%0h exp=1", multi_hit); end
    checks++; if (valid_count !== 4'd2) begin failures++; $display("FAIL dup_count got=%0h exp=2", valid_count); end
  endtask

  task automatic test_flush();
    flush = 1'b1;
    issue(ALLOC, 32'h33, '0);
    flush = 1'b0;
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL flush_rv got=%0h exp=0", resp_valid); end
    checks++; if (valid_count !== 4'd0 || full !== 1'b0) begin failures++; $display("FAIL flush_cnt got=%0h/%0h exp=0/0", valid_count, full); end
    issue(LOOKUP, 32'hAA, '0);
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL flush_lookup got=%0h exp=0", hit); end
    issue(ALLOC, 32'h44, '0);
    checks++; if (alloc_idx !== 3'd0 || evict !== 1'b0 || valid_count !== 4'd1) begin
      failures++; $display("FAIL flush_alloc got=idx%0h ev%0h c%0h exp=idx0 ev0 c1", alloc_idx, evict, valid_count); end
  endtask

  task automatic test_async_reset();
    do_reset();
    issue(ALLOC, 32'h1, '0);
    issue(ALLOC, 32'h2, '0);
    enable = 1'b1; cmd = ALLOC; data = 32'h3;
    @(negedge clock);
    checks++; if (alloc_idx !== 3'd2 || resp_valid !== 1'b1) begin failures++; $display("FAIL pre_rst got=%0h/%0h exp=2/1", alloc_idx, resp_valid); end
    #2 reset = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b0 || alloc_idx !== 3'd0 || valid_count !== 4'd0) begin
      failures++; $display("FAIL async_rst got=rv%0h idx%0h c%0h exp=rv0 idx0 c0", resp_valid, alloc_idx, valid_count); end
    enable = 1'b0; cmd = NOP;
    @(negedge clock);
    reset = 1'b1;
    issue(ALLOC, 32'h3, '0);
    checks++; if (alloc_idx !== 3'd0 || hit !== 1'b0 || evict !== 1'b0 || resp_valid !== 1'b1) begin
      failures++; $display("FAIL post_rst got=idx%0h hit%0h ev%0h rv%0h exp=idx0 hit0 ev0 rv1", alloc_idx, hit, evict, resp_valid); end
  endtask

  initial begin
    test_reset();
    test_write_lookup();
    test_alloc_fill();
    test_lru_touch();
    test_multi_hit();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
